// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing helpers.
// No logic of its own; latency and backpressure do not apply.
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA,
        STOP
    } rxState_t;

    localparam int MIN_CLKS_PER_BIT = 4;

    function automatic int clksPerBit(input int clkFreq, input int baudRate);
        return clkFreq / baudRate;
    endfunction

    function automatic int cntWidth(input int clksPerBitVal);
        return $clog2(clksPerBitVal);
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for one asynchronous bit, reset to a chosen level.
// Latency 2 clocks; no backpressure.
module bit_synchronizer #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic asyncBit,
    output logic syncBit
);

    logic metaBit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            metaBit <= RESET_VALUE;
            syncBit <= RESET_VALUE;
        end else begin
            metaBit <= asyncBit;
            syncBit <= metaBit;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: validates start/stop bits, strobes each good byte or a framing error.
// Latency 3 + HALF_BIT + 9*CLKS_PER_BIT clocks from start edge to strobe; no backpressure.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  UART_RECEIVER_CLOCK_50,
    input  logic                  UART_RECEIVER_RESET_InHigh,
    input  logic                  UART_RECEIVER_RX_In,
    output logic [DATA_WIDTH-1:0] UART_RECEIVER_DATAOUT_OutBus,
    output logic                  UART_RECEIVER_FLAGDATA_Out,
    output logic                  UART_RECEIVER_FRAMEERROR_Out
);

    localparam int CLKS_PER_BIT = clksPerBit(CLK_FREQ, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = cntWidth(CLKS_PER_BIT);
    localparam int IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SETTLE    = CNT_W'(2);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : gRateCheck
        $error("uart_receiver: CLK_FREQ / BAUD_RATE must be at least 4");
    end

    logic                  rxs;
    rxState_t              state;
    logic [CNT_W-1:0]      cycleCnt;
    logic [IDX_W-1:0]      bitIdx;
    logic [DATA_WIDTH-1:0] shiftReg;

    bit_synchronizer #(
        .RESET_VALUE (1'b1)
    ) rxSync (
        .clock    (UART_RECEIVER_CLOCK_50),
        .reset    (UART_RECEIVER_RESET_InHigh),
        .asyncBit (UART_RECEIVER_RX_In),
        .syncBit  (rxs)
    );

    always_ff @(posedge UART_RECEIVER_CLOCK_50 or posedge UART_RECEIVER_RESET_InHigh) begin
        if (UART_RECEIVER_RESET_InHigh) begin
            state                        <= WAIT_HIGH;
            cycleCnt                     <= '0;
            bitIdx                       <= '0;
            shiftReg                     <= '0;
            UART_RECEIVER_DATAOUT_OutBus <= '0;
            UART_RECEIVER_FLAGDATA_Out   <= 1'b0;
            UART_RECEIVER_FRAMEERROR_Out <= 1'b0;
        end else begin
            UART_RECEIVER_FLAGDATA_Out   <= 1'b0;
            UART_RECEIVER_FRAMEERROR_Out <= 1'b0;
            case (state)
                // The synchronizer's reset level of 1 says nothing about the real line,
                // so hold off until it has been refilled from the pin.
                WAIT_HIGH: begin
                    if (cycleCnt < SETTLE) begin
                        cycleCnt <= cycleCnt + 1'b1;
                    end else if (rxs) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (!rxs) begin
                        cycleCnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (cycleCnt == HALF_LAST) begin
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            cycleCnt <= '0;
                            bitIdx   <= '0;
                            state    <= DATA;
                        end
                    end else begin
                        cycleCnt <= cycleCnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cycleCnt == BIT_LAST) begin
                        cycleCnt <= '0;
                        shiftReg <= {rxs, shiftReg[DATA_WIDTH-1:1]};
                        if (bitIdx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            bitIdx <= bitIdx + 1'b1;
                        end
                    end else begin
                        cycleCnt <= cycleCnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop-bit lets an immediately following start bit be caught.
                    if (cycleCnt == BIT_LAST) begin
                        if (rxs) begin
                            UART_RECEIVER_DATAOUT_OutBus <= shiftReg;
                            UART_RECEIVER_FLAGDATA_Out   <= 1'b1;
                            state                        <= IDLE;
                        end else begin
                            UART_RECEIVER_FRAMEERROR_Out <= 1'b1;
                            state                        <= WAIT_HIGH;
                        end
                    end else begin
                        cycleCnt <= cycleCnt + 1'b1;
                    end
                end
                default: state <= WAIT_HIGH;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed-stimulus bench for uart_receiver with a queue-based scoreboard and strobe monitor.
module tb_uart_receiver;

    localparam int CPB     = 434;
    localparam int LATENCY = 4126;
    localparam int FAST    = 421;
    localparam int SLOW    = 447;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] dout;
    logic       flag;
    logic       ferr;

    always #10 clk = ~clk;

    uart_receiver #(
        .CLK_FREQ   (50000000),
        .BAUD_RATE  (115200),
        .DATA_WIDTH (8)
    ) dut (
        .UART_RECEIVER_CLOCK_50       (clk),
        .UART_RECEIVER_RESET_InHigh   (rst),
        .UART_RECEIVER_RX_In          (rx),
        .UART_RECEIVER_DATAOUT_OutBus (dout),
        .UART_RECEIVER_FLAGDATA_Out   (flag),
        .UART_RECEIVER_FRAMEERROR_Out (ferr)
    );

    typedef struct {
        bit         isErr;
        logic [7:0] data;
        int         expCyc;
    } exp_t;

    exp_t sbQ[$];
    int   cyc = 0;
    int   testsRun = 0;
    int   testsFailed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        testsRun++;
        if (act !== req) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        testsRun++;
        if (act < lo || act > hi) begin
            testsFailed++;
            $display("FAIL %s: got cycle %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: every strobe must match the oldest expected event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (flag === 1'b1 || ferr === 1'b1) begin
                check("strobe_exclusive", 32'(flag & ferr), 32'd0);
                if (sbQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("FAIL unexpected_strobe: flag=%b ferr=%b data=0x%02h at cycle %0d, required no strobe",
                             flag, ferr, dout, cyc);
                end else begin
                    e = sbQ.pop_front();
                    check("strobe_kind_ferr", 32'(ferr), 32'(e.isErr));
                    check("dataout", 32'(dout), 32'(e.data));
                    if (e.expCyc >= 0)
                        checkRange("strobe_latency", cyc, e.expCyc - 1, e.expCyc + 1);
                end
            end
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // expKind: 0 good byte, 1 framing error (DATAOUT must still show 'held').
    task automatic sendFrame(input logic [7:0] d, input int bitClks, input bit stopBit,
                             input int expKind, input logic [7:0] held, input bit checkLat);
        int lat;
        lat = checkLat ? cyc + LATENCY : -1;
        if (expKind == 0) sbQ.push_back('{isErr: 1'b0, data: d,    expCyc: lat});
        else              sbQ.push_back('{isErr: 1'b1, data: held, expCyc: lat});
        rx = 1'b0;
        repeat (bitClks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (bitClks) @(negedge clk);
        end
        rx = stopBit;
        repeat (bitClks) @(negedge clk);
    endtask

    initial begin
        logic [7:0] partial;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_dataout", 32'(dout), 32'd0);
        check("reset_flagdata", 32'(flag), 32'd0);
        check("reset_frameerror", 32'(ferr), 32'd0);
        rst = 1'b0;
        idle(2 * CPB);

        // Single byte
        sendFrame(8'h14, CPB, 1'b1, 0, 8'h00, 1'b1);
        idle(2 * CPB);

        // Back-to-back, no idle gap
        sendFrame(8'h09, CPB, 1'b1, 0, 8'h00, 1'b1);
        sendFrame(8'h0A, CPB, 1'b1, 0, 8'h00, 1'b1);
        idle(2 * CPB);

        // Glitch shorter than half a bit
        rx = 1'b0;
        repeat (100) @(negedge clk);
        idle(2 * CPB);
        sendFrame(8'h3C, CPB, 1'b1, 0, 8'h00, 1'b1);
        idle(2 * CPB);

        // Framing error, then break
        sendFrame(8'h55, CPB, 1'b0, 1, 8'h3C, 1'b1);
        rx = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        check("break_dataout_held", 32'(dout), 32'h3C);
        idle(2 * CPB);
        sendFrame(8'h01, CPB, 1'b1, 0, 8'h00, 1'b1);
        idle(2 * CPB);

        // Reset in the middle of bit 4 of 0xA5
        partial = 8'hA5;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            repeat (CPB) @(negedge clk);
        end
        rx = partial[4];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_dataout", 32'(dout), 32'd0);
        check("midreset_flagdata", 32'(flag), 32'd0);
        check("midreset_frameerror", 32'(ferr), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rx  = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check("post_reset_dataout", 32'(dout), 32'd0);
        idle(2 * CPB);
        sendFrame(8'h32, CPB, 1'b1, 0, 8'h00, 1'b1);
        idle(2 * CPB);

        // Rate tolerance at +3% and -3%
        sendFrame(8'hFF, FAST, 1'b1, 0, 8'h00, 1'b0);
        sendFrame(8'h00, FAST, 1'b1, 0, 8'h00, 1'b0);
        sendFrame(8'h5A, FAST, 1'b1, 0, 8'h00, 1'b0);
        idle(2 * CPB);
        sendFrame(8'hFF, SLOW, 1'b1, 0, 8'h00, 1'b0);
        sendFrame(8'h00, SLOW, 1'b1, 0, 8'h00, 1'b0);
        sendFrame(8'h5A, SLOW, 1'b1, 0, 8'h00, 1'b0);
        idle(2 * CPB);

        check("scoreboard_drained", 32'(sbQ.size()), 32'd0);
        check("final_dataout", 32'(dout), 32'h5A);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
